// File: rtl/mips_pkg.sv
// Shared MIPS fetch-side definitions: opcode constants, NOP word, fetch FSM encoding
// and small address/instruction helpers.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {instr, pc4} holding buffer used when a fetch returns while IF/ID is stalled.
// Clear and unload both empty the entry; clear has priority over load.
module if_skid_buf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc4,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc4
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;

  // Entry storage: emptied by clear/unload, filled by load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'h0000_0000;
    end else if (i_clear || i_unload) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, req/ack fetch FSM, IF/ID register and redirect squash.
// Optional IF_PERF_CNT_EN adds fetch and memory-stall counters.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [5:0]  ifid_opcode,
  output logic [31:0] ifid_pc4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc_plus4;
  logic [31:0] r_addr;
  logic        r_req;

  logic        r_ifid_valid;
  logic        w_ifid_valid_nxt;
  logic [31:0] r_ifid_instr;
  logic [31:0] w_ifid_instr_nxt;
  logic [31:0] w_ifid_data_nxt;
  logic [31:0] r_ifid_pc4;
  logic [31:0] w_ifid_pc4_nxt;
  logic        w_ifid_free;

  logic        w_skid_load;
  logic        w_skid_unload;
  logic        w_skid_clear;
  logic        w_skid_valid;
  logic [31:0] w_skid_instr;
  logic [31:0] w_skid_pc4;
  logic        w_fill;

  assign w_pc_plus4  = r_pc + WORD_BYTES;
  assign w_ifid_free = ~r_ifid_valid | id_ready;

  if_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (w_skid_clear),
    .i_instr  (imem_rdata),
    .i_pc4    (w_pc_plus4),
    .o_valid  (w_skid_valid),
    .o_instr  (w_skid_instr),
    .o_pc4    (w_skid_pc4)
  );

  // Next-state, PC and IF/ID update; a redirect overrides every other action.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_ifid_data_nxt  = r_ifid_instr;
    w_ifid_pc4_nxt   = r_ifid_pc4;
    w_skid_load      = 1'b0;
    w_skid_unload    = 1'b0;
    w_skid_clear     = 1'b0;
    w_fill           = 1'b0;
    if (r_ifid_valid && id_ready) begin
      w_ifid_valid_nxt = 1'b0;
    end else begin
      w_ifid_valid_nxt = r_ifid_valid;
    end

    if (redirect_valid) begin
      w_pc_nxt         = word_align(redirect_pc);
      w_ifid_valid_nxt = 1'b0;
      w_skid_clear     = 1'b1;
      case (r_state)
        // A request still in flight must be retired before the new address goes out.
        ST_REQ, ST_DRAIN: w_state_nxt = imem_ack ? ST_REQ : ST_DRAIN;
        default:          w_state_nxt = ST_REQ;
      endcase
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_REQ;
        end
        ST_REQ: begin
          if (imem_ack) begin
            w_pc_nxt = w_pc_plus4;
            if (w_ifid_free) begin
              w_fill           = 1'b1;
              w_ifid_valid_nxt = 1'b1;
              w_ifid_data_nxt  = imem_rdata;
              w_ifid_pc4_nxt   = w_pc_plus4;
            end else begin
              w_skid_load = 1'b1;
              w_state_nxt = ST_HOLD;
            end
          end else begin
            w_state_nxt = ST_REQ;
          end
        end
        ST_HOLD: begin
          if (id_ready) begin
            w_fill           = w_skid_valid;
            w_skid_unload    = 1'b1;
            w_ifid_valid_nxt = w_skid_valid;
            w_ifid_data_nxt  = w_skid_instr;
            w_ifid_pc4_nxt   = w_skid_pc4;
            w_state_nxt      = ST_REQ;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            w_state_nxt = ST_REQ;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign w_ifid_instr_nxt = w_ifid_valid_nxt ? w_ifid_data_nxt : NOP_INSTR;

  // FSM, PC and request registers; the issued address is frozen while draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= word_align(RESET_PC);
      r_addr  <= word_align(RESET_PC);
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_req   <= (w_state_nxt == ST_REQ) || (w_state_nxt == ST_DRAIN);
      if (w_state_nxt != ST_DRAIN) begin
        r_addr <= w_pc_nxt;
      end else begin
        r_addr <= r_addr;
      end
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc4   <= 32'h0000_0000;
    end else begin
      r_ifid_valid <= w_ifid_valid_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_pc4   <= w_ifid_pc4_nxt;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign ifid_valid  = r_ifid_valid;
  assign ifid_instr  = r_ifid_instr;
  assign ifid_opcode = opcode_of(r_ifid_instr);
  assign ifid_pc4    = r_ifid_pc4;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  // Free-running event counters; redirects do not clear them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetch <= 32'h0000_0000;
      r_perf_stall <= 32'h0000_0000;
    end else begin
      r_perf_fetch <= r_perf_fetch + {31'd0, w_fill};
      r_perf_stall <= r_perf_stall + {31'd0, (r_req & ~imem_ack)};
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
